// File: rtl/uart_rx.sv
// UART receiver: start bit, BIT_PER_WORD+1 data bits LSB first, one stop bit.
// Received words are held in a one-word register handed off with a valid/ack handshake.
module uart_rx #(
  parameter int DELAY_FRAMES = 2812,
  parameter int BIT_PER_WORD = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_pin,
  output logic [BIT_PER_WORD:0] data,
  output logic                  data_ready,
  input  logic                  data_ack,
  input  logic                  err_clear,
  output logic                  framing_error,
  output logic                  overrun,
  output logic                  sampled,
  output logic [5:0]            led
);

  localparam logic [24:0] HALF_CNT = 25'(DELAY_FRAMES / 2);
  localparam logic [24:0] BIT_CNT  = 25'(DELAY_FRAMES);
  localparam logic [7:0]  LAST_BIT = 8'(BIT_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    RECEIVE,
    STOP_BIT,
    WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic                  rx_meta;
  logic                  rx_s;
  logic [24:0]           tx_counter;
  logic [7:0]            bit_counter;
  logic [BIT_PER_WORD:0] shift_reg;

  logic cnt_clear;
  logic cnt_inc;
  logic bit_clear;
  logic bit_inc;
  logic deliver;
  logic frame_err_set;
  logic overrun_set;
  logic cnt_last;
  logic half_last;

  assign cnt_last    = (tx_counter + 25'd1) == BIT_CNT;
  assign half_last   = (tx_counter + 25'd1) == HALF_CNT;
  assign overrun_set = deliver && data_ready && !data_ack;

  // Reset loads the idle level so leaving reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    bit_clear     = 1'b0;
    bit_inc       = 1'b0;
    sampled       = 1'b0;
    deliver       = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START_BIT;
          cnt_clear  = 1'b1;
        end
      end
      START_BIT: begin
        // Half a bit in: a line that is high again was only a glitch
        if (half_last) begin
          cnt_clear = 1'b1;
          if (!rx_s) begin
            state_next = RECEIVE;
            bit_clear  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RECEIVE: begin
        if (cnt_last) begin
          sampled   = 1'b1;
          cnt_clear = 1'b1;
          if (bit_counter == LAST_BIT) state_next = STOP_BIT;
          else                         bit_inc    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP_BIT: begin
        if (cnt_last) begin
          cnt_clear = 1'b1;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = WAIT_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_counter    <= '0;
      bit_counter   <= '0;
      shift_reg     <= '0;
      data          <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (cnt_clear)    tx_counter <= '0;
      else if (cnt_inc) tx_counter <= tx_counter + 25'd1;

      if (bit_clear)    bit_counter <= '0;
      else if (bit_inc) bit_counter <= bit_counter + 8'd1;

      for (int i = 0; i <= BIT_PER_WORD; i++) begin
        if (sampled && bit_counter == 8'(i)) shift_reg[i] <= rx_s;
      end

      // A delivery in the same cycle as an ack replaces the word rather than clearing it
      if (deliver && (!data_ready || data_ack)) begin
        data       <= shift_reg;
        data_ready <= 1'b1;
      end else if (data_ready && data_ack) begin
        data_ready <= 1'b0;
      end

      if (frame_err_set)  framing_error <= 1'b1;
      else if (err_clear) framing_error <= 1'b0;

      if (overrun_set)    overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
    end
  end

  assign led[0] = (state == IDLE);
  assign led[1] = (state == START_BIT);
  assign led[2] = (state == RECEIVE);
  assign led[3] = (state == STOP_BIT);
  assign led[4] = (state == WAIT_IDLE);
  assign led[5] = framing_error | overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: frames are serialised by the bench and
// the received word, handshake and error flags are compared with a frame-level model.
module tb_uart_rx;

  localparam int DF  = 16;
  localparam int BPW = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_pin;
  logic [BPW:0] data;
  logic         data_ready;
  logic         data_ack;
  logic         err_clear;
  logic         framing_error;
  logic         overrun;
  logic         sampled;
  logic [5:0]   led;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model of the holding register and sticky flags
  logic [7:0] exp_data;
  logic       exp_ready;
  logic       exp_fe;
  logic       exp_ov;

  int cyc = 0;
  int samp_q[$];

  uart_rx #(.DELAY_FRAMES(DF), .BIT_PER_WORD(BPW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .data         (data),
    .data_ready   (data_ready),
    .data_ack     (data_ack),
    .err_clear    (err_clear),
    .framing_error(framing_error),
    .overrun      (overrun),
    .sampled      (sampled),
    .led          (led)
  );

  always #5 clk = ~clk;

  // Timestamp every sample pulse so spacing can be checked afterwards
  always @(negedge clk) begin
    cyc++;
    if (sampled) samp_q.push_back(cyc);
  end

  task automatic drive_bit(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, DF);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DF);
    drive_bit(stop, DF);
    if (stop) drive_bit(1'b1, 4);
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
  endtask

  task automatic do_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  // A good frame arriving with no ack in its delivery cycle
  task automatic model_deliver(input logic [7:0] b);
    if (!exp_ready) begin
      exp_data  = b;
      exp_ready = 1'b1;
    end else begin
      exp_ov = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_pin = 1'b1; data_ack = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h exp 00", data); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", data_ready); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b exp 00", {framing_error, overrun}); end
    checks++; if (sampled !== 1'b0) begin errors++; $display("[TB] FAIL reset_sampled got %b exp 0", sampled); end
    checks++; if (led !== 6'b000001) begin errors++; $display("[TB] FAIL reset_led got %b exp 000001", led); end
    rst = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
    drive_bit(1'b1, 4);
  endtask

  task automatic test_basic_frame();
    samp_q.delete();
    send_frame(8'hA5, 1'b1);
    model_deliver(8'hA5);
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL basic_data got %h exp %h", data, exp_data); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready got %b exp 1", data_ready); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags got %b exp 00", {framing_error, overrun}); end
    checks++;
    if (samp_q.size() !== 8) begin
      errors++; $display("[TB] FAIL basic_nsamples got %0d exp 8", samp_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (samp_q[i] - samp_q[i-1] !== DF) begin
          errors++; $display("[TB] FAIL basic_spacing%0d got %0d exp %0d", i, samp_q[i] - samp_q[i-1], DF);
        end
      end
    end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    exp_ready = 1'b0;
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL basic_ack got %b exp %b", data_ready, exp_ready); end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 3; g++) begin
      int len;
      len = $urandom_range(1, 6);
      samp_q.delete();
      drive_bit(1'b0, len);
      drive_bit(1'b1, 20);
      checks++; if (led !== 6'b000001) begin errors++; $display("[TB] FAIL glitch_led len %0d got %b exp 000001", len, led); end
      checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL glitch_ready got %b exp %b", data_ready, exp_ready); end
      checks++; if ({framing_error, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL glitch_flags got %b exp 00", {framing_error, overrun}); end
      checks++; if (samp_q.size() !== 0) begin errors++; $display("[TB] FAIL glitch_samples got %0d exp 0", samp_q.size()); end
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 40);
    exp_fe = 1'b1;
    checks++; if (framing_error !== exp_fe) begin errors++; $display("[TB] FAIL frm_fe got %b exp %b", framing_error, exp_fe); end
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL frm_ready got %b exp %b", data_ready, exp_ready); end
    checks++; if (led !== 6'b110000) begin errors++; $display("[TB] FAIL frm_led_wait got %b exp 110000", led); end
    drive_bit(1'b1, 8);
    checks++; if (led !== 6'b100001) begin errors++; $display("[TB] FAIL frm_led_idle got %b exp 100001", led); end
    send_frame(8'h55, 1'b1);
    model_deliver(8'h55);
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL frm_next_data got %h exp %h", data, exp_data); end
    checks++; if (framing_error !== exp_fe) begin errors++; $display("[TB] FAIL frm_sticky got %b exp %b", framing_error, exp_fe); end
    do_ack();
    exp_ready = 1'b0;
    do_clear();
    exp_fe = 1'b0;
    checks++; if (framing_error !== exp_fe) begin errors++; $display("[TB] FAIL frm_clear got %b exp %b", framing_error, exp_fe); end
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL frm_ready2 got %b exp %b", data_ready, exp_ready); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    model_deliver(8'h11);
    send_frame(8'h22, 1'b1);
    model_deliver(8'h22);
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL ovr_data got %h exp %h", data, exp_data); end
    checks++; if (overrun !== exp_ov) begin errors++; $display("[TB] FAIL ovr_flag got %b exp %b", overrun, exp_ov); end
    checks++; if (led[5] !== 1'b1) begin errors++; $display("[TB] FAIL ovr_led got %b exp 1", led[5]); end
    do_ack();
    exp_ready = 1'b0;
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL ovr_ack got %b exp %b", data_ready, exp_ready); end
    do_clear();
    exp_ov = 1'b0;
    checks++; if (overrun !== exp_ov) begin errors++; $display("[TB] FAIL ovr_clear got %b exp %b", overrun, exp_ov); end
    checks++; if (led !== 6'b000001) begin errors++; $display("[TB] FAIL ovr_led_clear got %b exp 000001", led); end
  endtask

  task automatic test_ack_on_delivery();
    int n;
    int guard;
    send_frame(8'h11, 1'b1);
    model_deliver(8'h11);
    n = 0;
    guard = 0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        while (n < 8 && guard < 400) begin
          @(negedge clk);
          guard++;
          if (sampled) n++;
        end
        // The stop bit is judged one bit time after the last data sample
        repeat (DF) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
      end
    join
    checks++; if (n !== 8) begin errors++; $display("[TB] FAIL aod_samples got %0d exp 8", n); end
    exp_data = 8'h22;
    exp_ready = 1'b1;
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL aod_data got %h exp %h", data, exp_data); end
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL aod_ready got %b exp %b", data_ready, exp_ready); end
    checks++; if (overrun !== exp_ov) begin errors++; $display("[TB] FAIL aod_overrun got %b exp %b", overrun, exp_ov); end
  endtask

  task automatic test_reset_mid_frame();
    drive_bit(1'b0, DF);
    drive_bit(1'b0, 3 * DF);
    drive_bit(1'b0, DF / 2);
    rst = 1'b1;
    rx_pin = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00; exp_ready = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL mid_rst_data got %h exp %h", data, exp_data); end
    checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL mid_rst_ready got %b exp %b", data_ready, exp_ready); end
    checks++; if ({sampled, framing_error, overrun} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_flags got %b exp 000", {sampled, framing_error, overrun}); end
    checks++; if (led !== 6'b000001) begin errors++; $display("[TB] FAIL mid_rst_led got %b exp 000001", led); end
    drive_bit(1'b1, 20);
    checks++; if (led !== 6'b000001) begin errors++; $display("[TB] FAIL mid_rst_idle got %b exp 000001", led); end
    send_frame(8'h0F, 1'b1);
    model_deliver(8'h0F);
    checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL mid_rst_next got %h exp %h", data, exp_data); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_next_flags got %b exp 00", {framing_error, overrun}); end
    do_ack();
    exp_ready = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic bad;
      b = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        send_frame(b, 1'b0);
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 8);
        exp_fe = 1'b1;
      end else begin
        send_frame(b, 1'b1);
        model_deliver(b);
      end
      checks++; if (data !== exp_data) begin errors++; $display("[TB] FAIL rnd%0d_data got %h exp %h", k, data, exp_data); end
      checks++; if (data_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd%0d_ready got %b exp %b", k, data_ready, exp_ready); end
      checks++; if ({framing_error, overrun} !== {exp_fe, exp_ov}) begin errors++; $display("[TB] FAIL rnd%0d_flags got %b exp %b", k, {framing_error, overrun}, {exp_fe, exp_ov}); end
      checks++; if (led !== {exp_fe | exp_ov, 5'b00001}) begin errors++; $display("[TB] FAIL rnd%0d_led got %b exp %b", k, led, {exp_fe | exp_ov, 5'b00001}); end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        exp_ready = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        do_clear();
        exp_fe = 1'b0;
        exp_ov = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_ack_on_delivery();
    test_reset_mid_frame();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
